// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared types and helpers for the FFT output reorder buffer.
// The bit-reversal helper is the same one the butterfly stages use to map
// sequence indices to bins.
package fft_bitrev_reorder_pkg;

    typedef enum logic {
        WR_WRITE,
        WR_RESYNC
    } wr_state_e;

    typedef enum logic {
        RD_IDLE,
        RD_READ
    } rd_state_e;

    localparam int MAX_STAGE = 32;

    // Reverse the lowest 'width' bits of 'value'; bits above 'width' come back as zero.
    function automatic logic [MAX_STAGE-1:0] bitrev(input logic [MAX_STAGE-1:0] value,
                                                    input int width);
        logic [MAX_STAGE-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_STAGE; i++) begin
            if (i < width) begin
                r[i] = value[width-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM holding both ping-pong banks, addressed by {bank, index}.
// One write port, one registered read port, no reset on storage so it maps to block RAM.
module fft_reorder_ram #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 36
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Write port and registered read port share the single clock.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Output reorder buffer for the streaming radix-2 FFT: takes frames in
// bit-reversed order and replays them in natural bin order through a
// ping-pong pair of banks, so writing and reading overlap without stalls.
module fft_bitrev_reorder
    import fft_bitrev_reorder_pkg::*;
#(
    parameter int TOTAL_STAGE_P = 10,
    parameter int MULT_WIDTH_P  = 18
) (
    input  logic                      iclk,
    input  logic                      rst,
    input  logic                      ien,
    input  logic [TOTAL_STAGE_P-1:0]  iaddr,
    input  logic [2*MULT_WIDTH_P-1:0] idata,
    output logic                      oen,
    output logic [TOTAL_STAGE_P-1:0]  oaddr,
    output logic [2*MULT_WIDTH_P-1:0] odata,
    output logic                      oerr
);

    localparam logic [TOTAL_STAGE_P-1:0] LAST_IDX = '1;

    wr_state_e                  wr_state_q, wr_state_d;
    logic                       wbank_q, wbank_d;
    logic [TOTAL_STAGE_P-1:0]   wcnt_q, wcnt_d;
    logic                       oerr_q, oerr_d;
    rd_state_e                  rd_state_q, rd_state_d;
    logic                       rbank_q, rbank_d;
    logic [TOTAL_STAGE_P-1:0]   rcnt_q, rcnt_d;
    logic [1:0]                 full_q, full_d;
    logic                       oen_q;
    logic [TOTAL_STAGE_P-1:0]   oaddr_q;

    logic                       wr_en;
    logic                       frame_done;
    logic [1:0]                 full_clr;
    logic [TOTAL_STAGE_P-1:0]   wr_idx;
    logic [2*MULT_WIDTH_P-1:0]  ram_rdata;

    assign wr_idx = TOTAL_STAGE_P'(bitrev(32'(iaddr), TOTAL_STAGE_P));

    // Writer: accept in-sequence samples, drop the frame and wait for index 0 on a sequence break.
    always_comb begin
        wr_state_d = wr_state_q;
        wbank_d    = wbank_q;
        wcnt_d     = wcnt_q;
        oerr_d     = oerr_q;
        wr_en      = 1'b0;
        frame_done = 1'b0;
        if (ien) begin
            case (wr_state_q)
                WR_WRITE: begin
                    if (iaddr == wcnt_q) begin
                        wr_en = 1'b1;
                        if (iaddr == LAST_IDX) begin
                            frame_done = 1'b1;
                            wbank_d    = ~wbank_q;
                            wcnt_d     = '0;
                        end else begin
                            wcnt_d = wcnt_q + 1'b1;
                        end
                    end else begin
                        oerr_d     = 1'b1;
                        wcnt_d     = '0;
                        wr_state_d = WR_RESYNC;
                    end
                end
                WR_RESYNC: begin
                    if (iaddr == '0) begin
                        wr_en      = 1'b1;
                        wcnt_d     = TOTAL_STAGE_P'(1);
                        wr_state_d = WR_WRITE;
                    end
                end
                default: wr_state_d = WR_WRITE;
            endcase
        end
    end

    // Reader: sweep a full bank in natural order, chaining straight into the other bank if it is ready.
    always_comb begin
        rd_state_d = rd_state_q;
        rbank_d    = rbank_q;
        rcnt_d     = rcnt_q;
        full_clr   = 2'b00;
        case (rd_state_q)
            RD_IDLE: begin
                if (full_q[rbank_q]) begin
                    rd_state_d = RD_READ;
                    rcnt_d     = '0;
                end
            end
            RD_READ: begin
                if (rcnt_q == LAST_IDX) begin
                    full_clr = 2'b01 << rbank_q;
                    rbank_d  = ~rbank_q;
                    rcnt_d   = '0;
                    if (!full_q[~rbank_q]) begin
                        rd_state_d = RD_IDLE;
                    end
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Frame-complete flags: the reader releases its bank while the writer may complete the other one.
    always_comb begin
        full_d = full_q & ~full_clr;
        if (frame_done) begin
            full_d = full_d | (2'b01 << wbank_q);
        end
    end

    // State, counters and the output alignment stage matching the one-cycle RAM read.
    always_ff @(posedge iclk) begin
        if (rst) begin
            wr_state_q <= WR_WRITE;
            wbank_q    <= 1'b0;
            wcnt_q     <= '0;
            oerr_q     <= 1'b0;
            rd_state_q <= RD_IDLE;
            rbank_q    <= 1'b0;
            rcnt_q     <= '0;
            full_q     <= 2'b00;
            oen_q      <= 1'b0;
            oaddr_q    <= '1;
        end else begin
            wr_state_q <= wr_state_d;
            wbank_q    <= wbank_d;
            wcnt_q     <= wcnt_d;
            oerr_q     <= oerr_d;
            rd_state_q <= rd_state_d;
            rbank_q    <= rbank_d;
            rcnt_q     <= rcnt_d;
            full_q     <= full_d;
            oen_q      <= (rd_state_q == RD_READ);
            oaddr_q    <= (rd_state_q == RD_READ) ? rcnt_q : '1;
        end
    end

    fft_reorder_ram #(
        .ADDR_W (TOTAL_STAGE_P + 1),
        .DATA_W (2*MULT_WIDTH_P)
    ) u_ram (
        .clk_i   (iclk),
        .we_i    (wr_en),
        .waddr_i ({wbank_q, wr_idx}),
        .wdata_i (idata),
        .raddr_i ({rbank_q, rcnt_q}),
        .rdata_o (ram_rdata)
    );

    assign oen   = oen_q;
    assign oaddr = oaddr_q;
    assign odata = oen_q ? ram_rdata : '0;
    assign oerr  = oerr_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for the FFT reorder buffer: an N=8 instance exercised with directed
// frames and an N=1024 instance fed random frames, both checked every cycle
// against a frame-level timeline model.
module tb_fft_bitrev_reorder;

    localparam int PA = 3;
    localparam int NA = 8;
    localparam int PB = 10;
    localparam int NB = 1024;
    localparam int DW = 36;

    logic clk = 1'b0;
    logic rst;

    logic          ienA, oenA, oerrA;
    logic [PA-1:0] iaddrA, oaddrA;
    logic [DW-1:0] idataA, odataA;
    logic          ienB, oenB, oerrB;
    logic [PB-1:0] iaddrB, oaddrB;
    logic [DW-1:0] idataB, odataB;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit armed = 0;
    int runLen = 0;
    int maxRun = 0;

    // Model state per instance (0 = N=8, 1 = N=1024)
    bit            inSync [2];
    int            expIdx [2];
    bit            modelErr [2];
    int            lastEnd [2];
    logic [DW-1:0] frameBuf [2][NB];
    int            expAddr [int];
    logic [DW-1:0] expData [int];

    // Clock generation
    always #5 clk = ~clk;

    fft_bitrev_reorder #(.TOTAL_STAGE_P(PA), .MULT_WIDTH_P(18)) dutA (
        .iclk(clk), .rst(rst), .ien(ienA), .iaddr(iaddrA), .idata(idataA),
        .oen(oenA), .oaddr(oaddrA), .odata(odataA), .oerr(oerrA)
    );

    fft_bitrev_reorder #(.TOTAL_STAGE_P(PB), .MULT_WIDTH_P(18)) dutB (
        .iclk(clk), .rst(rst), .ien(ienB), .iaddr(iaddrB), .idata(idataB),
        .oen(oenB), .oaddr(oaddrB), .odata(odataB), .oerr(oerrB)
    );

    // Arithmetic bit reversal of the low p bits
    function automatic int brev(input int v, input int p);
        int r = 0;
        int x = v;
        for (int k = 0; k < p; k++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    // Frame completed at edge e: schedule its N natural-order outputs on the output timeline
    task automatic completeFrame(input int id, input int p, input int e);
        int n = 1 << p;
        int start = (e + 2 > lastEnd[id] + 1) ? e + 2 : lastEnd[id] + 1;
        for (int j = 0; j < n; j++) begin
            expAddr[(start + j) * 2 + id] = j;
            expData[(start + j) * 2 + id] = frameBuf[id][brev(j, p)];
        end
        lastEnd[id] = start + n - 1;
    endtask

    // Advance the model by one clock edge given the inputs seen at that edge
    task automatic modelStep(input int id, input int p, input bit r, input bit en,
                             input int a, input logic [DW-1:0] d, input int e);
        int n = 1 << p;
        int keysQ[$];
        if (r) begin
            inSync[id]   = 1;
            expIdx[id]   = 0;
            modelErr[id] = 0;
            lastEnd[id]  = -100;
            foreach (expAddr[k]) if (k % 2 == id) keysQ.push_back(k);
            foreach (keysQ[i]) begin
                expAddr.delete(keysQ[i]);
                expData.delete(keysQ[i]);
            end
            return;
        end
        if (!en) return;
        if (inSync[id]) begin
            if (a == expIdx[id]) begin
                frameBuf[id][a] = d;
                if (a == n - 1) begin
                    completeFrame(id, p, e);
                    expIdx[id] = 0;
                end else begin
                    expIdx[id] = expIdx[id] + 1;
                end
            end else begin
                modelErr[id] = 1;
                inSync[id]   = 0;
            end
        end else if (a == 0) begin
            frameBuf[id][0] = d;
            inSync[id]      = 1;
            expIdx[id]      = 1;
        end
    endtask

    // Compare one instance's outputs against the model for the current cycle
    task automatic checkOutput(input int id, input int p, input logic en, input logic [PB-1:0] a,
                               input logic [DW-1:0] d, input logic er);
        int key = cyc * 2 + id;
        logic          eEn;
        logic [PB-1:0] eA;
        logic [DW-1:0] eD;
        if (expAddr.exists(key)) begin
            eEn = 1'b1;
            eA  = PB'(expAddr[key]);
            eD  = expData[key];
        end else begin
            eEn = 1'b0;
            eA  = PB'((1 << p) - 1);
            eD  = '0;
        end
        checks++;
        if (en !== eEn || a !== eA || d !== eD) begin
            errors++;
            $display("[TB] FAIL out%0d cyc %0d got en=%0b addr=%0d data=%h exp en=%0b addr=%0d data=%h",
                     id, cyc, en, a, d, eEn, eA, eD);
        end
        checks++;
        if (er !== modelErr[id]) begin
            errors++;
            $display("[TB] FAIL err%0d cyc %0d got %0b exp %0b", id, cyc, er, modelErr[id]);
        end
    endtask

    // Literal expectation check
    task automatic checkLiteral(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s cyc %0d got %0d exp %0d", name, cyc, got, exp);
        end
    endtask

    // Drive one input slot of the N=8 instance and let the next edge capture it
    task automatic applyStimulus(input bit en, input int a, input logic [DW-1:0] d);
        ienA   = en;
        iaddrA = PA'(a);
        idataA = d;
        @(posedge clk);
        #1;
    endtask

    // Drive one input slot of the N=1024 instance
    task automatic applyStimulusB(input bit en, input int a, input logic [DW-1:0] d);
        ienB   = en;
        iaddrB = PB'(a);
        idataB = d;
        @(posedge clk);
        #1;
    endtask

    // After a frame whose data equals its index: expect 0,4,2,6,1,5,3,7 from E+2, then idle
    task automatic checkSingle(input string name);
        int lit [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < NA; j++) begin
            checkLiteral({name, "_oen"}, 64'(oenA), 64'd1);
            checkLiteral({name, "_addr"}, 64'(oaddrA), 64'(j));
            checkLiteral({name, "_data"}, 64'(odataA), 64'(lit[j]));
            @(negedge clk);
        end
        checkLiteral({name, "_idle_oen"}, 64'(oenA), 64'd0);
        checkLiteral({name, "_idle_addr"}, 64'(oaddrA), 64'd7);
        checkLiteral({name, "_idle_data"}, 64'(odataA), 64'd0);
    endtask

    // Model update on every active edge
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        modelStep(0, PA, rst, ienA, int'(iaddrA), idataA, cyc);
        modelStep(1, PB, rst, ienB, int'(iaddrB), idataB, cyc);
    end

    // Compare both instances mid-cycle and track the longest contiguous oen run of the small one
    initial forever begin
        @(negedge clk);
        if (armed) begin
            checkOutput(0, PA, oenA, PB'(oaddrA), odataA, oerrA);
            checkOutput(1, PB, oenB, oaddrB, odataB, oerrB);
            runLen = oenA ? runLen + 1 : 0;
            if (runLen > maxRun) maxRun = runLen;
        end
    end

    // Watchdog so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog cyc %0d got timeout exp finish", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed and random scenarios
    initial begin
        logic [DW-1:0] rnd;
        bit found;
        rst = 1'b1;
        ienA = 0; iaddrA = '0; idataA = '0;
        ienB = 0; iaddrB = '0; idataB = '0;
        @(posedge clk);
        #1;
        armed = 1;
        @(negedge clk);
        checkLiteral("reset_oen", 64'(oenA), 64'd0);
        checkLiteral("reset_addr", 64'(oaddrA), 64'd7);
        checkLiteral("reset_data", 64'(odataA), 64'd0);
        checkLiteral("reset_err", 64'(oerrA), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) applyStimulus(0, 0, '0);

        $display("[TB] single frame");
        for (int i = 0; i < NA; i++) applyStimulus(1, i, DW'(i));
        ienA = 0;
        checkSingle("single");
        repeat (5) applyStimulus(0, 0, '0);

        $display("[TB] back-to-back frames");
        maxRun = 0;
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < NA; i++) applyStimulus(1, i, DW'(8 * f + i));
        repeat (20) applyStimulus(0, 0, '0);
        checkLiteral("b2b_run", 64'(maxRun), 64'd32);

        $display("[TB] gapped frame");
        for (int i = 0; i < NA; i++) begin
            if (i > 0) applyStimulus(0, 0, '0);
            applyStimulus(1, i, DW'(i));
        end
        ienA = 0;
        checkSingle("gapped");
        repeat (5) applyStimulus(0, 0, '0);

        $display("[TB] sequence error");
        applyStimulus(1, 0, DW'(100));
        applyStimulus(1, 1, DW'(101));
        applyStimulus(1, 2, DW'(102));
        @(negedge clk);
        checkLiteral("seq_err_before", 64'(oerrA), 64'd0);
        applyStimulus(1, 5, DW'(105));
        @(negedge clk);
        checkLiteral("seq_err_rise", 64'(oerrA), 64'd1);
        for (int i = 0; i < NA; i++) applyStimulus(1, i, DW'(i));
        ienA = 0;
        checkSingle("resync");
        checkLiteral("seq_err_sticky", 64'(oerrA), 64'd1);
        repeat (5) applyStimulus(0, 0, '0);

        $display("[TB] reset mid-output");
        for (int i = 0; i < NA; i++) applyStimulus(1, i, DW'(50 + i));
        ienA = 0;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (oenA === 1'b1 && oaddrA === 3'd3) found = 1;
        end
        checkLiteral("rst_wait_sample3", 64'(found), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkLiteral("rst_mid_oen", 64'(oenA), 64'd0);
        checkLiteral("rst_mid_addr", 64'(oaddrA), 64'd7);
        checkLiteral("rst_mid_data", 64'(odataA), 64'd0);
        checkLiteral("rst_mid_err", 64'(oerrA), 64'd0);
        repeat (5) applyStimulus(0, 0, '0);
        for (int i = 0; i < NA; i++) applyStimulus(1, i, DW'(i));
        ienA = 0;
        checkSingle("after_rst");
        repeat (5) applyStimulus(0, 0, '0);

        $display("[TB] random frames N=1024");
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < NB; i++) begin
                rnd = {4'($urandom), 32'($urandom)};
                applyStimulusB(1, i, rnd);
            end
        ienB = 0;
        repeat (NB + 20) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Output reorder buffer for the streaming radix-2 FFT/IFFT pipeline. It sits after the last butterfly stage and consumes that stage's `oen`/`oaddr`/`odata` stream, which carries each frame in bit-reversed index order. It emits the same frame in natural order (bin 0 … bin 2^TOTAL_STAGE_P−1) using a ping-pong pair of banks, so input and output run concurrently with no stall.

## Interface
- `TOTAL_STAGE_P`, default 10: log2 of frame length N; width of all addresses.
- `MULT_WIDTH_P`, default 18: width of each of re/im; a complex sample is 2*MULT_WIDTH_P bits, packed as in the butterfly stages.

Ports:
- `iclk`  in  1  single clock for the whole block.
- `rst`  in  1  reset; synchronous, active-high.
- `ien`  in  1  input sample valid (last stage `oen`).
- `iaddr`  in  TOTAL_STAGE_P  input sample sequence index 0..N−1 (last stage `oaddr`).
- `idata`  in  2*MULT_WIDTH_P  input sample (last stage `odata`).
- `oen`  out  1  output sample valid.
- `oaddr`  out  TOTAL_STAGE_P  natural-order bin index of `odata`; all-ones when idle.
- `odata`  out  2*MULT_WIDTH_P  output sample; 0 when idle.
- `oerr`  out  1  sticky sequence error; cleared only by `rst`.

## Operation
- Two banks of N entries each. `wbank` selects the write bank and `rbank` the read bank. `full[1:0]` holds per-bank frame-complete flags.
- Writer: on `ien`, write `idata` to `bank[wbank][bitrev(iaddr)]`, where `bitrev` reverses all TOTAL_STAGE_P bits. An internal `wcnt` tracks the expected `iaddr`.
- Frame completion: on `ien` with `iaddr == N−1`, set `full[wbank]`, toggle `wbank`, and reset `wcnt` to 0.
- Writer states are WRITE and RESYNC. Any `ien` with `iaddr != wcnt` in WRITE does the following:
  - sets `oerr`;
  - suppresses that write;
  - moves the writer to RESYNC. The current bank's partial contents are discarded and `full` is not set.
- RESYNC ignores samples until `ien` with `iaddr == 0`. That sample is written normally into the same `wbank`, and the writer returns to WRITE.
- `ien` low pauses the writer; gaps inside a frame are legal.
- Reader states are IDLE and READ.
  - IDLE → READ when `full[rbank]`. `rcnt` starts at 0.
  - READ: one read per cycle, with address `rcnt`, no gaps.
  - At `rcnt == N−1`: clear `full[rbank]` and toggle `rbank`. If `full[other]` is already set, the reader stays in READ with `rcnt` = 0 (back-to-back frames, no bubble); otherwise it goes to IDLE.
- Data path: the bank read is registered (1 cycle). `oen`/`oaddr` are delayed to align with read data.
- No backpressure. At 1 sample/cycle input the writer can never reach a bank still being read: a bank's read finishes before the other bank's frame can complete.
- Simultaneous events:
  - Reader clearing `full[x]` in the same cycle the writer sets `full[y]`, with x≠y: both take effect.
  - The writer setting `full[rbank]` while the reader is IDLE: the reader starts on the next cycle.

## Timing
- Reset: `oen`=0, `oaddr`=all-ones, `odata`=0, `oerr`=0, `full`=00, `wbank`=`rbank`=0, `wcnt`=`rcnt`=0. Writer goes to WRITE and reader to IDLE. RAM contents are not cleared.
- Reset asserted mid-frame aborts both sides immediately; `oen` is 0 from the next edge.
- Latency, with edge E capturing the last input sample of a frame into an empty reader:
  - E+1: reader enters READ with address 0.
  - E+2: `oen`=1, `oaddr`=0, `odata`=bin 0.
  - E+2 … E+N+1: `oen` stays high and `oaddr` increments by 1 each cycle.
- Idle output: `oen`=0, `oaddr`=all-ones, `odata`=0.
- `oerr` rises on the edge that captures the bad sample.

## Structure
- `fft_inc.h` (shared): `SIM_DLY` and a `bitrev` function parameterised by TOTAL_STAGE_P. The butterfly stages reuse the same function.
- Sub-module `fft_reorder_ram`: 2N×(2*MULT_WIDTH_P) simple dual-port RAM with one write port and one registered read port, addressed by {bank, index}. It is inferable as block RAM.
- Top level holds the writer FSM, reader FSM, `full` flags and output alignment registers.

## Test plan
Run with TOTAL_STAGE_P=3 (N=8) unless noted.
- Single frame: `iaddr`=0..7 with `idata`=iaddr (continuous) -> `oen` high 8 cycles starting 2 cycles after the last input edge; `odata` = 0,4,2,6,1,5,3,7 with `oaddr` = 0..7; then `oaddr`=7, `odata`=0, `oen`=0.
- Back-to-back frames: 4 frames continuous with data offset 8·f -> 32 contiguous `oen` cycles with no bubble; each frame is the reordered sequence plus its offset.
- Gapped input: frame with `ien` low every other cycle -> output identical to the single-frame case, starting 2 cycles after the final input.
- Sequence error: `iaddr` 0,1,2,5 then frame 0..7 -> `oerr`=1 from the 4th sample edge; only the second frame is output; `oerr` stays 1.
- Reset mid-output: `rst` pulsed at output sample 3 -> `oen`=0 next cycle and all reset values hold. A fresh frame then outputs correctly from bank 0.
- TOTAL_STAGE_P=10: random data, 3 continuous frames -> output matches a bit-reversal reference model exactly.
